// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin sharing of one serial ALU between NUM_REQ requesters,
// with 10-bit framing, reply checking, timeout recovery and local ALU reset.
module alu_req_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2,
  parameter int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [7:0]           resp_status,
  output logic [15:0]          resp_result,
  output logic [1:0]           resp_err,
  output logic                 alu_rst_n,
  output logic                 alu_enable_n,
  output logic                 alu_din,
  input  logic                 alu_dout,
  input  logic                 alu_dout_valid
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {S_ALU_RST, S_IDLE, S_SEND, S_WAIT, S_RECV, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q;
  logic [TW-1:0]      tcnt_q;
  logic [GW-1:0]      gap_q;
  logic [IDW-1:0]     last_q, id_q, gnt_idx;
  logic               gnt_hit, timeout_q;
  logic [29:0]        frame_q, sh_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               resp_valid_q, alu_rst_n_q, en_n_q, din_q;
  logic [IDW-1:0]     resp_id_q;
  logic [7:0]         status_q, st_c;
  logic [15:0]        result_q, res_c;
  logic [1:0]         err_q;
  logic [9:0]         w0, w1, w2;
  logic               is10, is30, bad;

  function automatic logic [9:0] mk(input logic c, input logic [7:0] p);
    return {c, p, c ^ (^p)};
  endfunction

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_status  = status_q;
  assign resp_result  = result_q;
  assign resp_err     = err_q;
  assign alu_rst_n    = alu_rst_n_q;
  assign alu_enable_n = en_n_q;
  assign alu_din      = din_q;

  // First pending requester strictly after the previous winner, wrapping around.
  always_comb begin
    gnt_idx = last_q;
    gnt_hit = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (!gnt_hit && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        gnt_hit = 1'b1;
        gnt_idx = IDW'((int'(last_q) + k) % NUM_REQ);
      end
  end

  // A 10-bit status-only reply ends up in the low word of the shifter.
  always_comb begin
    w0    = sh_q[29:20];
    w1    = sh_q[19:10];
    w2    = sh_q[9:0];
    is10  = cnt_q == 5'd10;
    is30  = cnt_q == 5'd30;
    bad   = is30 ? !(w0[9] && !w1[9] && !w2[9] && !(^w0) && !(^w1) && !(^w2)) :
            is10 ? !(w2[9] && !(^w2)) : 1'b1;
    st_c  = is30 ? w0[8:1] : is10 ? w2[8:1] : 8'h00;
    res_c = is30 ? {w1[8:1], w2[8:1]} : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_ALU_RST;
    else     state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ALU_RST: state_d = (cnt_q == 5'd1) ? S_IDLE : S_ALU_RST;
      S_IDLE:    state_d = (gap_q == '0 && !alu_dout_valid && gnt_hit) ? S_SEND : S_IDLE;
      S_SEND:    state_d = (cnt_q == 5'd29) ? S_WAIT : S_SEND;
      S_WAIT:    state_d = alu_dout_valid ? S_RECV :
                           (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) ? S_RESP : S_WAIT;
      S_RECV:    state_d = alu_dout_valid ? S_RECV : S_RESP;
      S_RESP:    state_d = !resp_ready ? S_RESP : timeout_q ? S_ALU_RST : S_IDLE;
      default:   state_d = S_ALU_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q        <= '0;
      tcnt_q       <= '0;
      gap_q        <= '0;
      last_q       <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      timeout_q    <= 1'b0;
      frame_q      <= '0;
      sh_q         <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      status_q     <= '0;
      result_q     <= '0;
      err_q        <= '0;
      alu_rst_n_q  <= 1'b0;
      en_n_q       <= 1'b1;
      din_q        <= 1'b0;
    end else begin
      req_ready_q <= '0;
      alu_rst_n_q <= state_d != S_ALU_RST;
      en_n_q      <= state_q != S_SEND;
      din_q       <= (state_q == S_SEND) ? frame_q[5'd29 - cnt_q] : 1'b0;
      case (state_q)
        S_ALU_RST: begin
          cnt_q <= (state_d == S_IDLE) ? 5'd0 : cnt_q + 5'd1;
          gap_q <= GW'(GAP_CYCLES);
        end
        S_IDLE: begin
          gap_q <= (gap_q != '0) ? gap_q - GW'(1) : gap_q;
          if (state_d == S_SEND) begin
            req_ready_q <= NUM_REQ'(1) << gnt_idx;
            id_q        <= gnt_idx;
            last_q      <= gnt_idx;
            cnt_q       <= '0;
            frame_q     <= {mk(1'b0, req_a[8*gnt_idx +: 8]), mk(1'b0, req_b[8*gnt_idx +: 8]),
                            mk(1'b1, req_op[8*gnt_idx +: 8])};
          end
        end
        S_SEND: begin
          cnt_q  <= cnt_q + 5'd1;
          tcnt_q <= '0;
        end
        S_WAIT: begin
          tcnt_q <= tcnt_q + TW'(1);
          if (alu_dout_valid) begin
            sh_q  <= {29'b0, alu_dout};
            cnt_q <= 5'd1;
          end else if (state_d == S_RESP) begin
            timeout_q    <= 1'b1;
            err_q        <= 2'b10;
            status_q     <= '0;
            result_q     <= '0;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
          end
        end
        S_RECV: begin
          // cnt_q saturates at 31 to flag an over-long reply.
          if (alu_dout_valid) begin
            if (cnt_q < 5'd30) sh_q <= {sh_q[28:0], alu_dout};
            if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
          end else begin
            timeout_q    <= 1'b0;
            err_q        <= {1'b0, bad};
            status_q     <= st_c;
            result_q     <= res_c;
            resp_id_q    <= id_q;
            resp_valid_q <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            gap_q        <= GW'(GAP_CYCLES);
            cnt_q        <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule
